// File: rtl/i2c_reg_bank.sv
// i2c_reg_bank
// Small register file sitting behind an I2C slave front end. The shift
// register presents a byte/word on data_i together with one command strobe;
// the bank keeps an auto-incrementing register pointer so multi-byte bursts
// land in consecutive registers.
//
// Parameters
//   DATA_W    register / data bus width (8..32)
//   NUM_REGS  number of registers (2..16)
//   WRAP      1: pointer wraps to 0 after the last register,
//             0: pointer saturates at the last register and flags err
//   RO_MASK   bit k = 1 makes register k read-only from the bus
//   RST_VAL   reset value of every register
//
// Ports
//   SCL       clock, rising edge active
//   rst_n     asynchronous active-low reset
//   data_i    word from the shift register
//   ptr_load  load the pointer from data_i
//   wr_en     write data_i to reg[ptr], then advance the pointer
//   rd_en     fetch reg[ptr] into data_o, then advance the pointer
//   data_o    registered read data
//   regs_o    flat register contents, register k at [k*DATA_W +: DATA_W]
//   ptr_o     current pointer
//   wr_ack    one-cycle pulse per committed write
//   err       sticky error flag (bad pointer, read-only write, saturation,
//             write/read collision)
module i2c_reg_bank #(
  parameter int                  DATA_W   = 8,
  parameter int                  NUM_REGS = 4,
  parameter int                  WRAP     = 1,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  parameter logic [DATA_W-1:0]   RST_VAL  = '0,
  localparam int                 ADDR_W   = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                         SCL,
  input  logic                         rst_n,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         ptr_load,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic [DATA_W-1:0]            data_o,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [ADDR_W-1:0]            ptr_o,
  output logic                         wr_ack,
  output logic                         err
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [ADDR_W-1:0] ptr;

  logic [ADDR_W-1:0] ptr_next;
  logic              sat_hit;
  logic              ptr_ok;
  logic              target_ro;

  // Pointer advance used by both wr_en and rd_en. At the last register the
  // pointer either wraps or stays put; staying put is reported as an error
  // but the access itself still goes ahead.
  always_comb begin
    ptr_next  = ptr + ADDR_W'(1);
    sat_hit   = 1'b0;
    if (ptr == ADDR_W'(NUM_REGS - 1)) begin
      if (WRAP != 0) begin
        ptr_next = '0;
      end else begin
        ptr_next = ptr;
        sat_hit  = 1'b1;
      end
    end
    ptr_ok    = (data_i < DATA_W'(NUM_REGS));
    target_ro = RO_MASK[ptr];
  end

  // Command execution. ptr_load beats wr_en beats rd_en; a simultaneous
  // wr_en + rd_en performs only the write (single advance) and flags err.
  always_ff @(posedge SCL or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        regs[k] <= RST_VAL;
      end
      ptr    <= '0;
      data_o <= '0;
      wr_ack <= 1'b0;
      err    <= 1'b0;
    end else begin
      wr_ack <= 1'b0;
      if (ptr_load) begin
        if (ptr_ok) begin
          ptr <= data_i[ADDR_W-1:0];
        end else begin
          err <= 1'b1;
        end
      end else if (wr_en) begin
        if (!target_ro) begin
          regs[ptr] <= data_i;
          wr_ack    <= 1'b1;
        end else begin
          err <= 1'b1;
        end
        ptr <= ptr_next;
        if (sat_hit || rd_en) begin
          err <= 1'b1;
        end
      end else if (rd_en) begin
        data_o <= regs[ptr];
        ptr    <= ptr_next;
        if (sat_hit) begin
          err <= 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign regs_o[k*DATA_W +: DATA_W] = regs[k];
  end

  assign ptr_o = ptr;

endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb_i2c_reg_bank
// Drives two copies of the register bank with identical stimulus:
//   dut_a : WRAP = 1, no read-only registers
//   dut_b : WRAP = 0, register 2 read-only
// Both are compared every cycle against a simple array-based model, and the
// directed scenarios additionally check hand-derived constants.
module tb_i2c_reg_bank;

  logic        SCL;
  logic        rst_n;
  logic [7:0]  data_i;
  logic        ptr_load;
  logic        wr_en;
  logic        rd_en;

  logic [7:0]  data_o_a, data_o_b;
  logic [31:0] regs_a, regs_b;
  logic [1:0]  ptr_a, ptr_b;
  logic        ack_a, ack_b;
  logic        err_a, err_b;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  logic [7:0] m_regs [2][4];
  int         m_ptr  [2];
  logic [7:0] m_dout [2];
  logic       m_ack  [2];
  logic       m_err  [2];
  int         m_wrap [2] = '{1, 0};
  logic [3:0] m_ro   [2] = '{4'b0000, 4'b0100};

  i2c_reg_bank #(.DATA_W(8), .NUM_REGS(4), .WRAP(1), .RO_MASK(4'b0000), .RST_VAL(8'h00)) dut_a (
    .SCL(SCL), .rst_n(rst_n), .data_i(data_i), .ptr_load(ptr_load), .wr_en(wr_en),
    .rd_en(rd_en), .data_o(data_o_a), .regs_o(regs_a), .ptr_o(ptr_a), .wr_ack(ack_a), .err(err_a));

  i2c_reg_bank #(.DATA_W(8), .NUM_REGS(4), .WRAP(0), .RO_MASK(4'b0100), .RST_VAL(8'h00)) dut_b (
    .SCL(SCL), .rst_n(rst_n), .data_i(data_i), .ptr_load(ptr_load), .wr_en(wr_en),
    .rd_en(rd_en), .data_o(data_o_b), .regs_o(regs_b), .ptr_o(ptr_b), .wr_ack(ack_b), .err(err_b));

  initial SCL = 1'b0;
  always #5 SCL = ~SCL;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] packRegs(input int c);
    logic [31:0] p;
    for (int k = 0; k < 4; k++) p[k*8 +: 8] = m_regs[c][k];
    return p;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < 4; k++) m_regs[c][k] = 8'h00;
      m_ptr[c]  = 0;
      m_dout[c] = 8'h00;
      m_ack[c]  = 1'b0;
      m_err[c]  = 1'b0;
    end
  endtask

  // One SCL edge of the behavioural model
  task automatic modelStep(input logic pl, input logic wr, input logic rd, input logic [7:0] d);
    for (int c = 0; c < 2; c++) begin
      m_ack[c] = 1'b0;
      if (pl) begin
        if (int'(d) < 4) m_ptr[c] = int'(d);
        else m_err[c] = 1'b1;
      end else if (wr || rd) begin
        if (wr) begin
          if (m_ro[c][m_ptr[c]] == 1'b0) begin
            m_regs[c][m_ptr[c]] = d;
            m_ack[c] = 1'b1;
          end else begin
            m_err[c] = 1'b1;
          end
          if (rd) m_err[c] = 1'b1;
        end else begin
          m_dout[c] = m_regs[c][m_ptr[c]];
        end
        if (m_ptr[c] < 3) m_ptr[c] = m_ptr[c] + 1;
        else if (m_wrap[c] != 0) m_ptr[c] = 0;
        else m_err[c] = 1'b1;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "/a.regs"}, regs_a, packRegs(0));
    cmp({tag, "/a.ptr"},  {30'd0, ptr_a}, 32'(m_ptr[0]));
    cmp({tag, "/a.dout"}, {24'd0, data_o_a}, {24'd0, m_dout[0]});
    cmp({tag, "/a.ack"},  {31'd0, ack_a}, {31'd0, m_ack[0]});
    cmp({tag, "/a.err"},  {31'd0, err_a}, {31'd0, m_err[0]});
    cmp({tag, "/b.regs"}, regs_b, packRegs(1));
    cmp({tag, "/b.ptr"},  {30'd0, ptr_b}, 32'(m_ptr[1]));
    cmp({tag, "/b.dout"}, {24'd0, data_o_b}, {24'd0, m_dout[1]});
    cmp({tag, "/b.ack"},  {31'd0, ack_b}, {31'd0, m_ack[1]});
    cmp({tag, "/b.err"},  {31'd0, err_b}, {31'd0, m_err[1]});
  endtask

  // Drive one command between edges, clock it in, then compare
  task automatic applyStimulus(input string tag, input logic pl, input logic wr,
                               input logic rd, input logic [7:0] d);
    @(negedge SCL);
    ptr_load = pl;
    wr_en    = wr;
    rd_en    = rd;
    data_i   = d;
    @(posedge SCL);
    modelStep(pl, wr, rd, d);
    #1;
    checkOutput(tag);
  endtask

  // Reset pulse placed entirely between two rising edges; outputs must
  // clear without any clock edge
  task automatic pulseReset(input string tag);
    @(negedge SCL);
    ptr_load = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] d;
    logic       pl, wr, rd;
    rst_n    = 1'b0;
    ptr_load = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_i   = 8'h00;
    modelReset();
    #3;
    checkOutput("reset");

    // Commands during reset are ignored
    @(negedge SCL);
    wr_en  = 1'b1;
    data_i = 8'hFF;
    @(posedge SCL);
    #1;
    checkOutput("cmd_in_reset");
    @(negedge SCL);
    wr_en = 1'b0;
    rst_n = 1'b1;

    // Burst write with wrap
    applyStimulus("burst_pl", 1, 0, 0, 8'h01);
    applyStimulus("burst_w1", 0, 1, 0, 8'hA1);
    applyStimulus("burst_w2", 0, 1, 0, 8'hB2);
    applyStimulus("burst_w3", 0, 1, 0, 8'hC3);
    cmp("burst_regs_a", regs_a, 32'hC3B2_A100);
    cmp("burst_ptr_a", {30'd0, ptr_a}, 32'd0);
    cmp("burst_ack_a", {31'd0, ack_a}, 32'd1);
    cmp("burst_err_a", {31'd0, err_a}, 32'd0);

    // Saturation on the WRAP = 0 copy
    pulseReset("rst_sat");
    applyStimulus("sat_pl", 1, 0, 0, 8'h03);
    applyStimulus("sat_rd1", 0, 0, 1, 8'h00);
    cmp("sat_ptr_b", {30'd0, ptr_b}, 32'd3);
    cmp("sat_err_b", {31'd0, err_b}, 32'd1);
    applyStimulus("sat_w", 0, 1, 0, 8'h5A);
    applyStimulus("sat_rd2", 0, 0, 1, 8'h00);
    cmp("sat_dout_b", {24'd0, data_o_b}, 32'h5A);
    cmp("sat_ptr_b2", {30'd0, ptr_b}, 32'd3);

    // Read-only register 2 on dut_b
    pulseReset("rst_ro");
    applyStimulus("ro_pl", 1, 0, 0, 8'h02);
    applyStimulus("ro_w", 0, 1, 0, 8'h55);
    cmp("ro_reg2_b", {24'd0, regs_b[23:16]}, 32'h00);
    cmp("ro_ack_b", {31'd0, ack_b}, 32'd0);
    cmp("ro_err_b", {31'd0, err_b}, 32'd1);
    cmp("ro_ptr_b", {30'd0, ptr_b}, 32'd3);
    cmp("ro_reg2_a", {24'd0, regs_a[23:16]}, 32'h55);

    // Out-of-range pointer load
    pulseReset("rst_badptr");
    applyStimulus("bad_pl1", 1, 0, 0, 8'h01);
    applyStimulus("bad_pl7", 1, 0, 0, 8'h07);
    cmp("bad_ptr_a", {30'd0, ptr_a}, 32'd1);
    cmp("bad_err_a", {31'd0, err_a}, 32'd1);
    applyStimulus("bad_pl2", 1, 0, 0, 8'h02);
    cmp("bad_ptr2_a", {30'd0, ptr_a}, 32'd2);

    // Write/read collision
    pulseReset("rst_coll");
    applyStimulus("coll_pl1", 1, 0, 0, 8'h01);
    applyStimulus("coll_w", 0, 1, 0, 8'h77);
    applyStimulus("coll_pl1b", 1, 0, 0, 8'h01);
    applyStimulus("coll_rd", 0, 0, 1, 8'h00);
    applyStimulus("coll_pl0", 1, 0, 0, 8'h00);
    applyStimulus("coll_wr_rd", 0, 1, 1, 8'h3C);
    cmp("coll_reg0_a", {24'd0, regs_a[7:0]}, 32'h3C);
    cmp("coll_dout_a", {24'd0, data_o_a}, 32'h77);
    cmp("coll_ptr_a", {30'd0, ptr_a}, 32'd1);
    cmp("coll_err_a", {31'd0, err_a}, 32'd1);

    // Reset in the middle of a burst
    pulseReset("rst_mid0");
    applyStimulus("mid_w1", 0, 1, 0, 8'h10);
    applyStimulus("mid_w2", 0, 1, 0, 8'h20);
    pulseReset("rst_mid");
    applyStimulus("mid_w3", 0, 1, 0, 8'h30);
    cmp("mid_regs_a", regs_a, 32'h0000_0030);
    cmp("mid_ptr_a", {30'd0, ptr_a}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 3) begin
        pulseReset("rand_rst");
      end else begin
        pl = ($urandom_range(0, 99) < 20);
        wr = $urandom_range(0, 1) == 1;
        rd = $urandom_range(0, 1) == 1;
        if ($urandom_range(0, 1) == 1) d = 8'($urandom_range(0, 7));
        else d = 8'($urandom);
        applyStimulus("rand", pl, wr, rd, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2c_reg_bank.md
I2C_REG_BANK -- requirements
Module: i2c_reg_bank

Interface
REQ-001 Parameter DATA_W, default 8, register and data-bus width in bits (legal 8..32).
REQ-002 Parameter NUM_REGS, default 4, number of registers (legal 2..16).
REQ-003 Parameter WRAP, default 1, pointer overflow mode: 1 = wrap to 0, 0 = saturate at NUM_REGS-1.
REQ-004 Parameter RO_MASK, default 0, NUM_REGS-bit mask; bit k = 1 makes register k read-only from the bus.
REQ-005 Parameter RST_VAL, default 0, DATA_W-bit reset value of every register.
REQ-006 SCL  input  1  clock, rising edge active.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 data_i  input  DATA_W  byte/word from the I2C shift register.
REQ-009 ptr_load  input  1  load the register pointer from data_i.
REQ-010 wr_en  input  1  write data_i to the register at the pointer, then advance the pointer.
REQ-011 rd_en  input  1  fetch the register at the pointer into data_o, then advance the pointer.
REQ-012 data_o  output  DATA_W  registered read data.
REQ-013 regs_o  output  NUM_REGS*DATA_W  flat register contents; register k at bits [k*DATA_W +: DATA_W].
REQ-014 ptr_o  output  ADDR_W  current pointer, where ADDR_W = max(1, clog2(NUM_REGS)).
REQ-015 wr_ack  output  1  one-cycle pulse when a write is committed.
REQ-016 err  output  1  sticky error flag.

Function
REQ-017 All state updates occur on the rising edge of SCL; regs_o, ptr_o and err are direct register outputs with no combinational path from inputs.
REQ-018 Priority within a cycle is ptr_load > wr_en > rd_en; only the highest-priority asserted command executes.
REQ-019 ptr_load: if data_i < NUM_REGS, ptr <= data_i[ADDR_W-1:0]; otherwise ptr is unchanged and err <= 1.
REQ-020 wr_en, target writable: reg[ptr] <= data_i and wr_ack = 1 in the following cycle; latency is 1 SCL edge.
REQ-021 wr_en, target read-only (RO_MASK[ptr] = 1): no register changes, wr_ack stays 0, err <= 1; the pointer still advances.
REQ-022 rd_en: data_o <= reg[ptr] on the same edge; data_o otherwise holds its value.
REQ-023 Pointer advance after wr_en or rd_en, when ptr < NUM_REGS-1: ptr <= ptr+1.
REQ-024 Pointer advance when ptr = NUM_REGS-1: WRAP = 1 gives ptr <= 0; WRAP = 0 keeps ptr at NUM_REGS-1 and sets err <= 1.
REQ-025 Saturation under WRAP = 0 does not block the access: a write to the last register commits (if writable) and a read returns it.
REQ-026 wr_en and rd_en together (without ptr_load): only the write executes, with a single pointer advance; data_o unchanged; err <= 1.
REQ-027 err is sticky; it clears only on reset.
REQ-028 wr_ack is high for exactly one cycle per committed write; back-to-back writes keep it high continuously.
REQ-029 Register contents never change except through a committed wr_en.

Reset
REQ-030 While rst_n = 0, independent of SCL: every register = RST_VAL, ptr_o = 0, data_o = 0, wr_ack = 0, err = 0.
REQ-031 Reset asserted mid-sequence aborts the current command; the first edge after release uses ptr = 0.
REQ-032 Commands asserted during reset have no effect.

Verification (DATA_W = 8, NUM_REGS = 4 unless stated)
REQ-033 Burst write: ptr_load with 0x01, then wr_en with 0xA1, 0xB2, 0xC3 -> reg1 = A1, reg2 = B2, reg3 = C3; ptr_o = 0 (WRAP = 1); wr_ack high for 3 cycles; err = 0.
REQ-034 Saturate (WRAP = 0): ptr_load with 0x03, then rd_en twice -> data_o = reg3 both times; ptr_o = 3; err = 1 after the first advance attempt.
REQ-035 Read-only (RO_MASK = 4'b0100): ptr_load with 0x02, then wr_en with 0x55 -> reg2 = RST_VAL; wr_ack = 0; err = 1; ptr_o = 3.
REQ-036 Bad pointer: ptr_load with 0x07 -> ptr_o unchanged, err = 1; a subsequent ptr_load with 0x02 still works.
REQ-037 Collision: wr_en and rd_en together at ptr 0 with data 0x3C -> reg0 = 3C, data_o unchanged, ptr_o = 1, err = 1.
REQ-038 Reset mid-burst: after two writes, pulse rst_n low between SCL edges -> all outputs return to reset values immediately; next wr_en writes reg0.
